// File: rtl/lsq_issue_arbiter_pkg.sv
// Shared types and helpers for the load/store issue arbiter.
package lsq_issue_arbiter_pkg;

    // Arbiter mode encoding (2 bits, legacy-compatible constants).
    typedef logic [1:0] lsq_arb_state_t;

    localparam lsq_arb_state_t ST_NORMAL      = 2'd0;
    localparam lsq_arb_state_t ST_STORE_BURST = 2'd1;
    localparam lsq_arb_state_t ST_FENCE_DRAIN = 2'd2;

    // Bits needed to hold the values 0..max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/lsq_issue_arbiter.sv
// Load/store issue arbiter: picks the head load or head store for the LSU
// address stage each cycle. Loads win by default; a bounded load streak
// forces a short store burst, and a fence drains every store before
// signalling completion. A presented request is held until accepted.
//
// state          | meaning
// ---------------+------------------------------------------------------
// ST_NORMAL      | loads preferred, stores issued when full or no load
// ST_STORE_BURST | loads masked, issue up to DRAIN_BURST stores
// ST_FENCE_DRAIN | loads masked, issue stores until the queue is empty
module lsq_issue_arbiter
    import lsq_issue_arbiter_pkg::*;
#(
    parameter int LOAD_STREAK_MAX = 8,
    parameter int DRAIN_BURST     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic lq_valid,
    input  logic lq_store_conflict,
    input  logic sq_valid,
    input  logic sq_full,
    input  logic sq_empty,
    input  logic fence_req,
    input  logic issue_ready,
    output logic issue_valid,
    output logic issue_load,
    output logic lq_pop,
    output logic sq_pop,
    output logic fence_done,
    output logic starve_active
);

    localparam int SW = cnt_width(LOAD_STREAK_MAX);
    localparam int BW = cnt_width(DRAIN_BURST);

    localparam logic [SW-1:0] STREAK_LIMIT = SW'(LOAD_STREAK_MAX);
    localparam logic [BW-1:0] BURST_LIMIT  = BW'(DRAIN_BURST);

    lsq_arb_state_t  state_q;
    lsq_arb_state_t  state_d;
    logic [SW-1:0]   streak_q;
    logic [SW-1:0]   streak_d;
    logic [SW-1:0]   streak_post;
    logic [BW-1:0]   burst_q;
    logic [BW-1:0]   burst_d;
    logic [BW-1:0]   burst_post;
    logic            hold_valid_q;
    logic            hold_load_q;
    logic            hold_valid_d;
    logic            hold_load_d;

    logic            load_ok;
    logic            sel_valid;
    logic            sel_load;
    logic            load_issue;
    logic            store_issue;
    logic            drain_complete;

    // Pick the request to present; a held request always wins so the
    // downstream never sees a retraction or a type switch.
    always_comb begin
        load_ok   = lq_valid & ~lq_store_conflict & (state_q == ST_NORMAL);
        sel_valid = 1'b0;
        sel_load  = 1'b0;
        if (hold_valid_q) begin
            sel_valid = 1'b1;
            sel_load  = hold_load_q;
        end else if (state_q == ST_NORMAL) begin
            if (sq_full & sq_valid) begin
                sel_valid = 1'b1;
                sel_load  = 1'b0;
            end else if (load_ok) begin
                sel_valid = 1'b1;
                sel_load  = 1'b1;
            end else if (sq_valid) begin
                sel_valid = 1'b1;
                sel_load  = 1'b0;
            end
        end else if (sq_valid) begin
            sel_valid = 1'b1;
            sel_load  = 1'b0;
        end
    end

    // Handshake results and the hold register's next value.
    always_comb begin
        load_issue     = sel_valid & issue_ready & sel_load;
        store_issue    = sel_valid & issue_ready & ~sel_load;
        hold_valid_d   = sel_valid & ~issue_ready;
        hold_load_d    = sel_load;
        drain_complete = (state_q == ST_FENCE_DRAIN) & sq_empty & ~hold_valid_q;
    end

    // Counter values after this cycle's acceptance; transitions look at these.
    always_comb begin
        streak_post = streak_q;
        if (store_issue | ~sq_valid) begin
            streak_post = '0;
        end else if (load_issue && (streak_q != STREAK_LIMIT)) begin
            streak_post = streak_q + SW'(1);
        end

        burst_post = burst_q;
        if ((state_q == ST_STORE_BURST) && store_issue && (burst_q != BURST_LIMIT)) begin
            burst_post = burst_q + BW'(1);
        end
    end

    // Mode transitions; a fence outranks both the streak threshold and a
    // running store burst, and is ignored while a drain is already active.
    always_comb begin
        state_d  = state_q;
        streak_d = streak_post;
        burst_d  = burst_post;
        case (state_q)
            ST_NORMAL: begin
                if (fence_req) begin
                    state_d = ST_FENCE_DRAIN;
                end else if ((streak_post == STREAK_LIMIT) && sq_valid) begin
                    state_d  = ST_STORE_BURST;
                    streak_d = '0;
                    burst_d  = '0;
                end
            end
            ST_STORE_BURST: begin
                if (fence_req) begin
                    state_d = ST_FENCE_DRAIN;
                end else if ((burst_post == BURST_LIMIT) || ~sq_valid) begin
                    state_d = ST_NORMAL;
                end
            end
            ST_FENCE_DRAIN: begin
                if (drain_complete) begin
                    state_d  = ST_NORMAL;
                    streak_d = '0;
                end
            end
            default: begin
                state_d  = ST_NORMAL;
                streak_d = '0;
                burst_d  = '0;
            end
        endcase
    end

    // State, counters and hold register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_NORMAL;
            streak_q     <= '0;
            burst_q      <= '0;
            hold_valid_q <= 1'b0;
            hold_load_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            burst_q      <= burst_d;
            hold_valid_q <= hold_valid_d;
            hold_load_q  <= hold_load_d;
        end
    end

    // Outputs are forced low in any cycle where reset is asserted.
    always_comb begin
        issue_valid   = sel_valid & ~rst;
        issue_load    = sel_load & sel_valid & ~rst;
        lq_pop        = load_issue & ~rst;
        sq_pop        = store_issue & ~rst;
        fence_done    = drain_complete & ~rst;
        starve_active = (state_q == ST_STORE_BURST) & ~rst;
    end

endmodule

// File: tb/tb_lsq_issue_arbiter.sv
// Randomized scoreboard bench for lsq_issue_arbiter with a small
// load/store queue environment and a behavioural reference model.
module tb_lsq_issue_arbiter;

    localparam int LSM    = 8;
    localparam int DB     = 2;
    localparam int SQ_CAP = 6;
    localparam int LQ_CAP = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lq_valid = 1'b0;
    logic lq_store_conflict = 1'b0;
    logic sq_valid = 1'b0;
    logic sq_full = 1'b0;
    logic sq_empty = 1'b1;
    logic fence_req = 1'b0;
    logic issue_ready = 1'b0;
    logic issue_valid;
    logic issue_load;
    logic lq_pop;
    logic sq_pop;
    logic fence_done;
    logic starve_active;

    always #5 clk = ~clk;

    lsq_issue_arbiter #(
        .LOAD_STREAK_MAX(LSM),
        .DRAIN_BURST    (DB)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .lq_valid         (lq_valid),
        .lq_store_conflict(lq_store_conflict),
        .sq_valid         (sq_valid),
        .sq_full          (sq_full),
        .sq_empty         (sq_empty),
        .fence_req        (fence_req),
        .issue_ready      (issue_ready),
        .issue_valid      (issue_valid),
        .issue_load       (issue_load),
        .lq_pop           (lq_pop),
        .sq_pop           (sq_pop),
        .fence_done       (fence_done),
        .starve_active    (starve_active)
    );

    typedef struct packed {
        logic        v;
        logic        ld;
        logic        lp;
        logic        sp;
        logic        fd;
        logic        st;
        logic [31:0] cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: what the arbiter is currently "doing" in plain terms.
    bit m_in_burst  = 0;
    bit m_in_fence  = 0;
    bit m_held      = 0;
    bit m_held_ld   = 0;
    int m_loads_run = 0;
    int m_burst_cnt = 0;

    // Environment queues and traffic knobs (percentages).
    int lq_cnt = 0;
    int sq_cnt = 0;
    int p_rst = 100, p_larr = 0, p_sarr = 0, p_rel = 100, p_conf = 0, p_fence = 0, p_rdy = 100;

    function automatic bit chance(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    task automatic model_step(input bit r, input bit lqv, input bit conf, input bit sqv,
                              input bit full, input bit empty, input bit fence, input bit rdy,
                              output exp_t e);
        bit v, ld, lp, sp, fd;
        e = '0;
        if (r) begin
            m_in_burst = 0; m_in_fence = 0; m_held = 0; m_held_ld = 0;
            m_loads_run = 0; m_burst_cnt = 0;
            return;
        end
        v = 0; ld = 0;
        fd = m_in_fence && empty && !m_held;
        if (m_held) begin
            v = 1; ld = m_held_ld;
        end else if (m_in_burst || m_in_fence) begin
            v = sqv;
        end else if (full && sqv) begin
            v = 1;
        end else if (lqv && !conf) begin
            v = 1; ld = 1;
        end else if (sqv) begin
            v = 1;
        end
        lp = v && rdy && ld;
        sp = v && rdy && !ld;
        e.v = v; e.ld = ld; e.lp = lp; e.sp = sp; e.fd = fd; e.st = m_in_burst;

        m_held    = v && !rdy;
        m_held_ld = ld;
        if (sp || !sqv) m_loads_run = 0;
        else if (lp && m_loads_run < LSM) m_loads_run++;

        if (m_in_fence) begin
            if (fd) begin
                m_in_fence  = 0;
                m_loads_run = 0;
            end
        end else if (fence) begin
            m_in_fence = 1;
            m_in_burst = 0;
        end else if (m_in_burst) begin
            if (sp) m_burst_cnt++;
            if (m_burst_cnt >= DB || !sqv) m_in_burst = 0;
        end else if (m_loads_run == LSM && sqv) begin
            m_in_burst  = 1;
            m_burst_cnt = 0;
            m_loads_run = 0;
        end
    endtask

    task automatic run_cycles(input int n);
        bit r, lqv, conf, sqv, full, empty, fence, rdy;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            r     = chance(p_rst);
            lqv   = lq_cnt > 0;
            conf  = lqv && chance(p_conf);
            sqv   = (sq_cnt > 0) && chance(p_rel);
            full  = sq_cnt == SQ_CAP;
            empty = sq_cnt == 0;
            fence = chance(p_fence);
            rdy   = chance(p_rdy);
            rst = r; lq_valid = lqv; lq_store_conflict = conf; sq_valid = sqv;
            sq_full = full; sq_empty = empty; fence_req = fence; issue_ready = rdy;
            model_step(r, lqv, conf, sqv, full, empty, fence, rdy, e);
            e.cyc = 32'(cyc);
            exp_q.push_back(e);
            if (e.lp) lq_cnt--;
            if (e.sp) sq_cnt--;
            if (chance(p_larr) && lq_cnt < LQ_CAP) lq_cnt++;
            if (chance(p_sarr) && sq_cnt < SQ_CAP) sq_cnt++;
            cyc++;
        end
    endtask

    task automatic set_knobs(input int rs, input int la, input int sa, input int rl,
                             input int cf, input int fn, input int rd);
        p_rst = rs; p_larr = la; p_sarr = sa; p_rel = rl; p_conf = cf; p_fence = fn; p_rdy = rd;
    endtask

    task automatic chk(input string name, input logic act, input logic req, input logic [31:0] c);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, c, act, req);
        end
    endtask

    // Monitor: compares the DUT's presented outputs with the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("issue_valid", issue_valid, e.v, e.cyc);
                if (e.v) chk("issue_load", issue_load, e.ld, e.cyc);
                chk("lq_pop", lq_pop, e.lp, e.cyc);
                chk("sq_pop", sq_pop, e.sp, e.cyc);
                chk("fence_done", fence_done, e.fd, e.cyc);
                chk("starve_active", starve_active, e.st, e.cyc);
            end
        end
    end

    initial begin
        //        rst larr sarr rel conf fence rdy
        set_knobs(100, 100, 0, 100, 0, 0, 100);  run_cycles(3);
        set_knobs(0, 100, 0, 100, 0, 0, 100);    run_cycles(20);
        set_knobs(0, 100, 100, 100, 0, 0, 100);  run_cycles(200);
        set_knobs(0, 70, 60, 90, 10, 0, 40);     run_cycles(400);
        set_knobs(0, 60, 30, 80, 10, 4, 70);     run_cycles(400);
        set_knobs(0, 80, 60, 100, 60, 1, 80);    run_cycles(300);
        set_knobs(0, 100, 100, 100, 0, 3, 25);   run_cycles(300);
        set_knobs(2, 60, 50, 80, 20, 3, 60);     run_cycles(1000);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
